// File: rtl/reg_pwm_bank_pkg.sv
// Shared types for the register-driven PWM bank: the per-channel
// configuration word layout and the helper that splits a register into it.
package reg_pwm_pkg;

  // Counter / shadow width; a register carries period and duty side by side.
  localparam int CW = 16;
  localparam int RW = 2 * CW;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] duty;
  } pwm_cfg_t;

  // Upper half of the register is the period, lower half the duty.
  function automatic pwm_cfg_t reg_to_cfg(input logic [RW-1:0] word);
    pwm_cfg_t cfg;
    cfg.period = word[RW-1:CW];
    cfg.duty   = word[CW-1:0];
    return cfg;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow period/duty that only reload at a period boundary
// (or on any tick while idle), a tick counter, and registered output/strobe.
module pwm_channel
  import reg_pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick,
  input  pwm_cfg_t cfg,
  output logic     pwm,
  output logic     strobe
);

  logic [CW-1:0] ps;
  logic [CW-1:0] ds;
  logic [CW-1:0] cnt;
  logic          running;
  logic          rollover;
  logic          active;

  // Period of zero parks the channel; cnt < ps guarantees ps-1 never wraps when running.
  assign running  = (ps != '0);
  assign rollover = running && (cnt == ps - CW'(1));
  assign active   = running && (cnt < ds);

  // Shadow registers and counter advance only on the shared tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps  <= '0;
      ds  <= '0;
      cnt <= '0;
    end else if (tick) begin
      if (!running || rollover) begin
        ps  <= cfg.period;
        ds  <= cfg.duty;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Output follows the current state one clk later; strobe marks the rollover reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm    <= ACTIVE_LOW;
      strobe <= 1'b0;
    end else begin
      pwm    <= active ? ~ACTIVE_LOW : ACTIVE_LOW;
      strobe <= tick && rollover;
    end
  end

endmodule

// File: rtl/reg_pwm_bank.sv
// Bank of independent PWM channels configured straight from the live register
// image. A shared prescaler produces the PWM tick; each channel picks up its
// register glitch-free at its own period boundary.
module reg_pwm_bank
  import reg_pwm_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int REG_DEPTH  = 16,
  parameter int N_CHANNELS = 8,
  parameter int BASE_REG   = 0,
  parameter int PRESCALE   = 50,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                             clk,
  input  logic                             i_reset_n,
  input  logic [WORD_WIDTH*REG_WIDTH-1:0]  i_mem [REG_DEPTH],
  output logic [N_CHANNELS-1:0]            o_pwm,
  output logic [N_CHANNELS-1:0]            o_period_strobe
);

  localparam int REG_BITS = WORD_WIDTH * REG_WIDTH;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Elaboration-time sanity checks on the configuration.
  if (REG_BITS % 2 != 0) begin : g_err_odd
    $error("reg_pwm_bank: register width must be even");
  end
  if (REG_BITS != RW) begin : g_err_width
    $error("reg_pwm_bank: register width must be twice the channel counter width");
  end
  if (BASE_REG + N_CHANNELS > REG_DEPTH) begin : g_err_depth
    $error("reg_pwm_bank: channel window exceeds register depth");
  end
  if (PRESCALE < 1) begin : g_err_prescale
    $error("reg_pwm_bank: PRESCALE must be at least 1");
  end

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PW'(PRESCALE - 1));

  // Prescaler: counts 0..PRESCALE-1, tick on the terminal count.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Registers outside the bank's window belong to other blocks and are ignored here.
  logic mem_unused;
  always_comb begin
    mem_unused = 1'b0;
    for (int r = 0; r < REG_DEPTH; r++) begin
      if (r < BASE_REG || r >= BASE_REG + N_CHANNELS) begin
        mem_unused = mem_unused ^ (^i_mem[r]);
      end
    end
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    pwm_cfg_t cfg;
    assign cfg = reg_to_cfg(i_mem[BASE_REG + c]);

    pwm_channel #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst_n  (i_reset_n),
      .tick   (tick),
      .cfg    (cfg),
      .pwm    (o_pwm[c]),
      .strobe (o_period_strobe[c])
    );
  end

endmodule
